// File: rtl/gpio_edge_irq_pkg.sv
// gpio_edge_irq_pkg: shared types and helpers for the GPIO edge-interrupt block.
//   fltcfg_t   - FLTCFG register contents (prescaler reload and filter enable)
//   be_to_mask - expands the 4 byte-write enables into a 32-bit bit mask
package gpio_edge_irq_pkg;

   typedef struct packed {
      logic       fen;
      logic [7:0] pre;
   } fltcfg_t;

   function automatic logic [31:0] be_to_mask(input logic [3:0] be);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) begin
         m[8*i +: 8] = {8{be[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/gpio_edge_irq_if.sv
// gpio_edge_irq_if: single-cycle register bus.
//   sel   - access strobe, one cycle per access
//   addr  - byte address, addr[5:2] picks the register
//   we    - byte write enables, all zero means read
//   wdata - write data
//   rdata - read data, registered, valid the cycle after sel
interface gpio_edge_irq_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned AWIDTH = 8
) ();
   logic              sel;
   logic [AWIDTH-1:0] addr;
   logic [3:0]        we;
   logic [XLEN-1:0]   wdata;
   logic [XLEN-1:0]   rdata;

   modport master (output sel, addr, we, wdata, input rdata);
   modport slave  (input sel, addr, we, wdata, output rdata);
endinterface

// File: rtl/gpio_edge_irq_regs.vh
// gpio_edge_irq register map: byte offsets (addr[5:0], word aligned) and FLTCFG field
// positions. Included inside the body of every module that decodes or checks the map.
// No ports; localparams only.
localparam logic [5:0] RegDin    = 6'h00;
localparam logic [5:0] RegDout   = 6'h04;
localparam logic [5:0] RegDset   = 6'h08;
localparam logic [5:0] RegDclr   = 6'h0C;
localparam logic [5:0] RegDir    = 6'h10;
localparam logic [5:0] RegIe     = 6'h14;
localparam logic [5:0] RegIrise  = 6'h18;
localparam logic [5:0] RegIfall  = 6'h1C;
localparam logic [5:0] RegIstat  = 6'h20;
localparam logic [5:0] RegFltcfg = 6'h24;

localparam int unsigned FltPreLsb = 0;
localparam int unsigned FltPreMsb = 7;
localparam int unsigned FltFenBit = 8;

// File: rtl/gpio_pin_filter.sv
// gpio_pin_filter: one pin's 2-flop synchroniser followed by a digital glitch filter.
//   clk, rst_n - clock, synchronous active-low reset
//   pin        - asynchronous pad input
//   tick       - shared prescaler sample strobe
//   fen        - 1: filter on; 0: level follows the synchronised input
//   level      - filtered level (registered)
module gpio_pin_filter #(
   parameter int unsigned FLT_DEPTH = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   input  logic tick,
   input  logic fen,
   output logic level
);
   // Wide enough to hold FLT_DEPTH-1 for FLT_DEPTH in 2..8.
   localparam int unsigned CW = $clog2(FLT_DEPTH);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      if (!fen) begin
         level_d = sync2_q;
         cnt_d   = '0;
      end else if (tick) begin
         if (sync2_q == level_q) begin
            cnt_d = '0;  // a sample matching the current level breaks the run
         end else if (cnt_q == CW'(FLT_DEPTH - 1)) begin
            level_d = sync2_q;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= pin;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
endmodule

// File: rtl/gpio_edge_irq.sv
// gpio_edge_irq: GPIO block with per-pin filtering and edge-triggered interrupts.
//   clk, rst_n   - clock, synchronous active-low reset
//   bus          - register bus (slave side)
//   gpio_pin_in  - asynchronous pad inputs
//   gpio_pin_out - pad output data (DOUT)
//   gpio_pin_oe  - pad output enable, 1 = drive (DIR)
//   irq          - level interrupt, registered |(ISTAT & IE)
module gpio_edge_irq
   import gpio_edge_irq_pkg::*;
#(
   parameter int unsigned NPIN      = 16,
   parameter int unsigned FLT_DEPTH = 3,
   parameter int unsigned XLEN      = 32,
   parameter int unsigned AWIDTH    = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   gpio_edge_irq_if.slave  bus,
   input  logic [NPIN-1:0] gpio_pin_in,
   output logic [NPIN-1:0] gpio_pin_out,
   output logic [NPIN-1:0] gpio_pin_oe,
   output logic            irq
);
   `include "gpio_edge_irq_regs.vh"

   logic [NPIN-1:0] dout_q, dout_d, dir_q, dir_d, ie_q, ie_d;
   logic [NPIN-1:0] irise_q, irise_d, ifall_q, ifall_d, istat_q, istat_d;
   fltcfg_t         flt_q, flt_d;
   logic [7:0]      pre_cnt_q, pre_cnt_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            irq_q;
   logic [NPIN-1:0] level, level_prev_q, hw_set, istat_clr;
   logic            tick, wr_en, flt_wr;
   logic [5:0]      reg_off;
   logic [XLEN-1:0] wmask, wbits;
   logic [NPIN-1:0] wmask_pin, wbits_pin;
   logic            unused_bits;

   assign reg_off   = {bus.addr[5:2], 2'b00};
   assign wr_en     = bus.sel && (bus.we != 4'b0000);
   assign wmask     = XLEN'(be_to_mask(bus.we));
   assign wbits     = bus.wdata & wmask;
   assign wmask_pin = wmask[NPIN-1:0];
   assign wbits_pin = wbits[NPIN-1:0];
   assign unused_bits = ^{bus.addr[AWIDTH-1:6], bus.addr[1:0], wbits, wmask};

   // Shared sample strobe; any FLTCFG write restarts the count.
   assign tick      = (pre_cnt_q == flt_q.pre);
   assign pre_cnt_d = (flt_wr || tick) ? 8'd0 : pre_cnt_q + 8'd1;

   for (genvar i = 0; i < NPIN; i++) begin : g_pin
      gpio_pin_filter #(
         .FLT_DEPTH(FLT_DEPTH)
      ) u_filter (
         .clk  (clk),
         .rst_n(rst_n),
         .pin  (gpio_pin_in[i]),
         .tick (tick),
         .fen  (flt_q.fen),
         .level(level[i])
      );
   end

   // Edges come only from the filtered level versus its previous-cycle value.
   assign hw_set = (level & ~level_prev_q & irise_q) | (~level & level_prev_q & ifall_q);

   always_comb begin
      dout_d    = dout_q;
      dir_d     = dir_q;
      ie_d      = ie_q;
      irise_d   = irise_q;
      ifall_d   = ifall_q;
      flt_d     = flt_q;
      istat_clr = '0;
      flt_wr    = 1'b0;
      if (wr_en) begin
         case (reg_off)
            RegDout:  dout_d  = (dout_q & ~wmask_pin) | wbits_pin;
            RegDset:  dout_d  = dout_q | wbits_pin;
            RegDclr:  dout_d  = dout_q & ~wbits_pin;
            RegDir:   dir_d   = (dir_q & ~wmask_pin) | wbits_pin;
            RegIe:    ie_d    = (ie_q & ~wmask_pin) | wbits_pin;
            RegIrise: irise_d = (irise_q & ~wmask_pin) | wbits_pin;
            RegIfall: ifall_d = (ifall_q & ~wmask_pin) | wbits_pin;
            RegIstat: istat_clr = wbits_pin;
            RegFltcfg: begin
               flt_wr    = 1'b1;
               flt_d.pre = (flt_q.pre & ~wmask[FltPreMsb:FltPreLsb]) | wbits[FltPreMsb:FltPreLsb];
               if (wmask[FltFenBit]) flt_d.fen = wbits[FltFenBit];
            end
            default: ;
         endcase
      end
      // Hardware set wins over a simultaneous software clear.
      istat_d = (istat_q & ~istat_clr) | hw_set;
   end

   always_comb begin
      rdata_d = '0;
      if (bus.sel) begin
         case (reg_off)
            RegDin:   rdata_d[NPIN-1:0] = level;
            RegDout:  rdata_d[NPIN-1:0] = dout_q;
            RegDir:   rdata_d[NPIN-1:0] = dir_q;
            RegIe:    rdata_d[NPIN-1:0] = ie_q;
            RegIrise: rdata_d[NPIN-1:0] = irise_q;
            RegIfall: rdata_d[NPIN-1:0] = ifall_q;
            RegIstat: rdata_d[NPIN-1:0] = istat_q;
            RegFltcfg: begin
               rdata_d[FltPreMsb:FltPreLsb] = flt_q.pre;
               rdata_d[FltFenBit]           = flt_q.fen;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout_q       <= '0;
         dir_q        <= '0;
         ie_q         <= '0;
         irise_q      <= '0;
         ifall_q      <= '0;
         istat_q      <= '0;
         flt_q        <= '0;
         pre_cnt_q    <= '0;
         rdata_q      <= '0;
         irq_q        <= 1'b0;
         level_prev_q <= '0;
      end else begin
         dout_q       <= dout_d;
         dir_q        <= dir_d;
         ie_q         <= ie_d;
         irise_q      <= irise_d;
         ifall_q      <= ifall_d;
         istat_q      <= istat_d;
         flt_q        <= flt_d;
         pre_cnt_q    <= pre_cnt_d;
         rdata_q      <= rdata_d;
         irq_q        <= |(istat_q & ie_q);
         level_prev_q <= level;
      end
   end

   assign gpio_pin_out = dout_q;
   assign gpio_pin_oe  = dir_q;
   assign irq          = irq_q;
   assign bus.rdata    = rdata_q;
endmodule

// File: doc/gpio_edge_irq.md
GPIO_EDGE_IRQ -- requirements
Module: gpio_edge_irq

Interface
REQ-001 Parameter NPIN, default 16, number of bidirectional GPIO pins (1..32).
REQ-002 Parameter FLT_DEPTH, default 3, consecutive equal samples required to accept a new input level (2..8).
REQ-003 Parameter XLEN, default 32, bus data width.
REQ-004 Parameter AWIDTH, default 8, bus byte-address width.
REQ-005 clk  input  1  single clock; one clock, reset is synchronous and active-low.
REQ-006 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-007 gpio_pin_in  input  NPIN  asynchronous pad inputs.
REQ-008 gpio_pin_out  output  NPIN  pad output data.
REQ-009 gpio_pin_oe  output  NPIN  pad output enable, 1 = drive.
REQ-010 sel  input  1  block select, one-cycle access strobe.
REQ-011 addr  input  AWIDTH  byte address; addr[5:2] selects the register.
REQ-012 we  input  4  byte write enables; we[n] writes wdata[8n+7:8n]; we=0 with sel=1 is a read.
REQ-013 wdata  input  XLEN  write data.
REQ-014 rdata  output  XLEN  read data.
REQ-015 irq  output  1  level interrupt request.

Function
REQ-016 Register map: 0x00 DIN RO, 0x04 DOUT RW, 0x08 DSET W1S, 0x0C DCLR W1C, 0x10 DIR RW, 0x14 IE RW, 0x18 IRISE RW, 0x1C IFALL RW, 0x20 ISTAT W1C, 0x24 FLTCFG RW ([7:0] PRE, [8] FEN); unmapped offsets read 0, writes ignored.
REQ-017 Bits at or above NPIN in all pin registers read 0 and ignore writes; DSET/DCLR read 0.
REQ-018 rdata registered: data of the register addressed in cycle N appears in cycle N+1; rdata = 0 in any cycle following sel=0.
REQ-019 Writes take effect on the clock edge ending the sel cycle; a read in the same cycle as a write returns the pre-write value.
REQ-020 gpio_pin_out = DOUT, gpio_pin_oe = DIR, both driven directly from flops.
REQ-021 Each pin passes through a 2-flop synchroniser before any other logic.
REQ-022 Prescaler: counter 0..PRE, sample tick when count == PRE, then wraps to 0; PRE = 0 gives a tick every cycle; a write to FLTCFG restarts the counter at 0.
REQ-023 FEN = 1: on each tick, a pin's filtered level updates to the synchronised value only after FLT_DEPTH consecutive ticks sample the same value differing from the current filtered level.
REQ-024 FEN = 0: filtered level = synchronised value, registered once; pin change to DIN latency is exactly 3 clocks.
REQ-025 DIN reads the filtered level of every pin, regardless of DIR.
REQ-026 Edge detect compares filtered level with its previous-cycle value; a 0->1 change with IRISE[i] = 1, or a 1->0 change with IFALL[i] = 1, sets ISTAT[i] on the next edge.
REQ-027 ISTAT sets regardless of IE; a hardware set and a software W1C of the same bit in the same cycle leave the bit set.
REQ-028 irq is registered: irq = |(ISTAT & IE) of the previous cycle.
REQ-029 Toggling FEN or IRISE/IFALL creates no spurious edge; the previous-cycle comparison alone defines edges.

Reset
REQ-030 While rst_n = 0 at a clock edge, the following clear: DOUT, DIR, IE, IRISE, IFALL, ISTAT, FLTCFG, prescaler, filter counters, rdata and irq.
REQ-031 Synchroniser and filtered-level flops reset to 0; a pin held high emerges from reset as a rising change but sets no ISTAT, because IRISE = 0.
REQ-032 Reset asserted mid-filter discards partial sample counts.

Structure
REQ-033 Register offsets and field positions are localparams in shared header gpio_edge_irq_regs.vh, included by the RTL and the bench.
REQ-034 Per-pin synchroniser plus filter is a sub-module gpio_pin_filter, instantiated NPIN times by generate; the prescaler tick is shared.

Verification
REQ-035 Write DIR = 0x00FF, DOUT = 0x00A5 -> gpio_pin_oe = 0x00FF, gpio_pin_out = 0x00A5; DSET 0x0100 then DCLR 0x0001 -> DOUT reads 0x01A4.
REQ-036 FEN = 0, pin 3 set 0->1 at cycle 0 -> DIN[3] = 1 from cycle 3; with IRISE = 0x8 and IE = 0x8 -> ISTAT = 0x8 at cycle 4, irq = 1 at cycle 5.
REQ-037 FEN = 1, PRE = 3, FLT_DEPTH = 3, pin 0 glitches high for 8 clocks -> DIN[0] stays 0; held high for 20 clocks -> DIN[0] rises.
REQ-038 ISTAT = 0x1, and a new rising edge on pin 0 sets the bit in the same cycle as a W1C 0x1 -> ISTAT stays 0x1; a later W1C clears it and irq drops one cycle later.
REQ-039 Byte write we = 4'b0010, wdata = 0xFFFFFFFF to IE -> IE = 0x0000FF00; read of offset 0x3C -> 0.
REQ-040 Assert rst_n = 0 for one cycle mid-filter with all registers non-zero -> all registers read 0, irq = 0, gpio_pin_oe = 0.
